// File: rtl/thermometer_decoder.sv
// Two-stage signed-binary to thermometer decoder with valid/ready backpressure and flush.
// Optional one-hot output (bit |v|-1) is enabled by defining THERMO_DEC_ONEHOT_EN.
module thermometer_decoder #(
   parameter int WIDTH     = 64,
   parameter int LOG_WIDTH = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LOG_WIDTH:0]   in_value,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_thermo,
   output logic                 out_sign,
   output logic                 out_zero
`ifdef THERMO_DEC_ONEHOT_EN
   ,
   output logic [WIDTH-1:0]     out_onehot
`endif
);

   logic                 s2_load;
   logic                 s1_load;

   logic                 s1_valid_q, s1_valid_d;
   logic                 s1_sign_q,  s1_sign_d;
   logic [LOG_WIDTH:0]   s1_mag_q,   s1_mag_d;

   logic                 out_valid_q,  out_valid_d;
   logic [WIDTH-1:0]     out_thermo_q, out_thermo_d;
   logic                 out_sign_q,   out_sign_d;
   logic                 out_zero_q,   out_zero_d;
`ifdef THERMO_DEC_ONEHOT_EN
   logic [WIDTH-1:0]     out_onehot_q, out_onehot_d;
`endif

   always_comb begin
      s2_load  = !out_valid_q || out_ready;
      s1_load  = !s1_valid_q || s2_load;
      in_ready = s1_load && !clear;

      s1_valid_d   = s1_valid_q;
      s1_sign_d    = s1_sign_q;
      s1_mag_d     = s1_mag_q;
      out_valid_d  = out_valid_q;
      out_thermo_d = out_thermo_q;
      out_sign_d   = out_sign_q;
      out_zero_d   = out_zero_q;
`ifdef THERMO_DEC_ONEHOT_EN
      out_onehot_d = out_onehot_q;
`endif

      if (clear) begin
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
               // Magnitude range is 0..WIDTH, so WIDTH itself naturally yields all ones.
               for (int i = 0; i < WIDTH; i++) begin
                  out_thermo_d[i] = (int'(s1_mag_q) > i);
`ifdef THERMO_DEC_ONEHOT_EN
                  out_onehot_d[i] = (int'(s1_mag_q) == i + 1);
`endif
               end
               out_sign_d = s1_sign_q;
               out_zero_d = (s1_mag_q == '0);
            end
         end
         if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
               s1_sign_d = in_value[LOG_WIDTH];
               s1_mag_d  = in_value[LOG_WIDTH] ? (~in_value + {{LOG_WIDTH{1'b0}}, 1'b1})
                                               : in_value;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_mag_q     <= '0;
         out_valid_q  <= 1'b0;
         out_thermo_q <= '0;
         out_sign_q   <= 1'b0;
         out_zero_q   <= 1'b0;
`ifdef THERMO_DEC_ONEHOT_EN
         out_onehot_q <= '0;
`endif
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_sign_q    <= s1_sign_d;
         s1_mag_q     <= s1_mag_d;
         out_valid_q  <= out_valid_d;
         out_thermo_q <= out_thermo_d;
         out_sign_q   <= out_sign_d;
         out_zero_q   <= out_zero_d;
`ifdef THERMO_DEC_ONEHOT_EN
         out_onehot_q <= out_onehot_d;
`endif
      end
   end

   assign out_valid  = out_valid_q;
   assign out_thermo = out_thermo_q;
   assign out_sign   = out_sign_q;
   assign out_zero   = out_zero_q;
`ifdef THERMO_DEC_ONEHOT_EN
   assign out_onehot = out_onehot_q;
`endif

endmodule
